// File: rtl/packet_buffer_tx_drain.sv
// Drains packets from the TX packet_buffer slot FIFO into an AXI-Stream-style master.
// A 2-entry output FIFO covers the one-cycle read latency and downstream backpressure.
//
// state | meaning
// IDLE  | waiting for packet_avail_i; latches size and word count
// READ  | issuing word reads while the output FIFO has room
// ACK   | one-cycle slot release; last word lands in the FIFO
module packet_buffer_tx_drain #(
  parameter int  data_width_p  = 64,
  parameter int  els_p         = 2048,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int size_width_lp = $clog2(els_p+1),
  localparam int keep_width_lp = data_width_p/8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     packet_avail_i,
  input  logic [size_width_lp-1:0] packet_rsize_i,
  output logic                     packet_rvalid_o,
  output logic [addr_width_lp-1:0] packet_raddr_o,
  input  logic [data_width_p-1:0]  packet_rdata_i,
  output logic                     packet_ack_o,
  output logic                     tx_tvalid_o,
  input  logic                     tx_tready_i,
  output logic [data_width_p-1:0]  tx_tdata_o,
  output logic [keep_width_lp-1:0] tx_tkeep_o,
  output logic                     tx_tlast_o,
  output logic [31:0]              tx_packet_count_o
);

  localparam int kw_log_lp = $clog2(keep_width_lp);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, ACK = 2'd2} state_e;
  state_e state_r, state_n;

  logic [size_width_lp-1:0] size_r, idx_r, last_idx_r, last_idx_n;
  logic [size_width_lp:0]   size_round;
  logic [kw_log_lp-1:0]     rem;
  logic [keep_width_lp-1:0] last_keep, infl_keep_r;
  logic                     infl_r, infl_last_r, is_last, issue, deq;
  logic [1:0]               fifo_count_r, occ;
  logic                     wr_ptr_r, rd_ptr_r;
  logic [data_width_p-1:0]  data_mem [2];
  logic [keep_width_lp-1:0] keep_mem [2];
  logic [1:0]               last_mem;

  assign size_round = {1'b0, packet_rsize_i} + (size_width_lp+1)'(keep_width_lp - 1);
  assign last_idx_n = size_width_lp'((size_round >> kw_log_lp) - (size_width_lp+1)'(1));

  assign rem       = size_r[kw_log_lp-1:0];
  assign last_keep = (rem == '0) ? '1 : ~({keep_width_lp{1'b1}} << rem);
  assign is_last   = (idx_r == last_idx_r);

  assign tx_tvalid_o = (fifo_count_r != 2'd0);
  assign deq         = tx_tvalid_o & tx_tready_i;
  assign occ         = fifo_count_r + {1'b0, infl_r};
  // occ never exceeds 2, so "occ - deq < 2" reduces to this
  assign issue       = (state_r == READ) && ((occ < 2'd2) || deq);

  assign packet_rvalid_o = issue;
  assign packet_raddr_o  = addr_width_lp'({idx_r, {kw_log_lp{1'b0}}});

  assign tx_tdata_o = data_mem[rd_ptr_r];
  assign tx_tkeep_o = keep_mem[rd_ptr_r];
  assign tx_tlast_o = last_mem[rd_ptr_r];

  always_comb begin
    state_n      = state_r;
    packet_ack_o = 1'b0;
    case (state_r)
      IDLE: if (packet_avail_i) state_n = (packet_rsize_i != '0) ? READ : ACK;
      READ: if (issue && is_last) state_n = ACK;
      ACK: begin
        packet_ack_o = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r           <= IDLE;
      size_r            <= '0;
      idx_r             <= '0;
      last_idx_r        <= '0;
      tx_packet_count_o <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && packet_avail_i) begin
        size_r     <= packet_rsize_i;
        last_idx_r <= last_idx_n;
        idx_r      <= '0;
      end else if (issue) begin
        idx_r <= idx_r + size_width_lp'(1);
      end
      if (state_r == ACK && size_r != '0) tx_packet_count_o <= tx_packet_count_o + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      infl_r       <= 1'b0;
      infl_last_r  <= 1'b0;
      infl_keep_r  <= '0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      fifo_count_r <= 2'd0;
      last_mem     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        keep_mem[i] <= '0;
      end
    end else begin
      infl_r <= issue;
      if (issue) begin
        infl_last_r <= is_last;
        infl_keep_r <= is_last ? last_keep : '1;
      end
      if (infl_r) begin
        data_mem[wr_ptr_r] <= packet_rdata_i;
        keep_mem[wr_ptr_r] <= infl_keep_r;
        last_mem[wr_ptr_r] <= infl_last_r;
        wr_ptr_r           <= ~wr_ptr_r;
      end
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      fifo_count_r <= fifo_count_r + {1'b0, infl_r} - {1'b0, deq};
    end
  end

endmodule
